// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the FIFO write-side arbiter: state encoding and default sizing
// that must agree with the async FIFO top.
package fifo_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CNT_W     = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure):
// a lone valid wins, two valids go to the requester that was not served last.
module rr_pick2 (
  input  logic [1:0] vld,
  input  logic       rr,
  output logic       any,
  output logic       sel
);

  assign any = |vld;
  assign sel = (vld == 2'b11) ? ~rr : vld[1];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, frame-locked sharing of one FIFO write port between two producers.
// Write path is combinational (zero latency); W_FULL stalls the granted producer without preemption.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] REQ0_DATA,
  input  logic             REQ0_VLD,
  input  logic             REQ0_LAST,
  output logic             REQ0_RDY,
  input  logic [WIDTH-1:0] REQ1_DATA,
  input  logic             REQ1_VLD,
  input  logic             REQ1_LAST,
  output logic             REQ1_RDY,
  input  logic             W_FULL,
  output logic [WIDTH-1:0] W_DATA,
  output logic             W_INC,
  output logic [1:0]       GNT,
  output logic             BURST_ERR
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic             rr, rr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             burst_err_nxt;

  logic             busy, own, own_vld, own_last, own_rdy, acc, rel;
  logic [1:0]       pick_vld;
  logic             pick_rr, pick_any, pick_sel;

  assign busy     = (state != ST_IDLE);
  assign own      = (state == ST_GNT1);
  assign own_vld  = own ? REQ1_VLD  : REQ0_VLD;
  assign own_last = own ? REQ1_LAST : REQ0_LAST;
  assign own_rdy  = busy && !W_FULL && !RST;
  assign acc      = own_vld && own_rdy;
  assign rel      = acc && (own_last || (cnt == CNT_LAST));

  // On release only the other producer may take over; otherwise fall back to IDLE.
  assign pick_vld = !busy ? {REQ1_VLD, REQ0_VLD}
                  : own   ? {1'b0, REQ0_VLD}
                  :         {REQ1_VLD, 1'b0};
  assign pick_rr  = busy ? own : rr;

  rr_pick2 u_pick (
    .vld (pick_vld),
    .rr  (pick_rr),
    .any (pick_any),
    .sel (pick_sel)
  );

  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr;
    cnt_nxt       = cnt;
    burst_err_nxt = BURST_ERR;
    REQ0_RDY      = 1'b0;
    REQ1_RDY      = 1'b0;
    W_INC         = 1'b0;
    W_DATA        = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) state_nxt = pick_sel ? ST_GNT1 : ST_GNT0;
      end
      ST_GNT0, ST_GNT1: begin
        REQ0_RDY = !own && own_rdy;
        REQ1_RDY = own && own_rdy;
        W_INC    = acc;
        W_DATA   = own ? REQ1_DATA : REQ0_DATA;
        if (rel) begin
          rr_nxt  = own;
          cnt_nxt = '0;
          if (!own_last) burst_err_nxt = 1'b1;
          state_nxt = !pick_any ? ST_IDLE : (pick_sel ? ST_GNT1 : ST_GNT0);
        end else if (acc) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      rr        <= 1'b1;
      cnt       <= '0;
      BURST_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      cnt       <= cnt_nxt;
      BURST_ERR <= burst_err_nxt;
    end
  end

  assign GNT = {state == ST_GNT1, state == ST_GNT0};

endmodule
